// File: rtl/xpu_vpu_pc_tn_vlsu_index_icq_rd_if.sv
// AGU-side index bus of the VLSU ICQ read stage: one-deep register output
// with valid/ready handshake.
interface xpu_vpu_pc_tn_vlsu_index_icq_rd_if #(
  parameter int IDX_WIDTH = 64
);
  logic                 agu_idx_vld;
  logic                 agu_idx_rdy;
  logic [IDX_WIDTH-1:0] agu_idx_offset;
  logic                 agu_idx_vmask;
  logic                 agu_idx_last;

  modport master (
    output agu_idx_vld,
    output agu_idx_offset,
    output agu_idx_vmask,
    output agu_idx_last,
    input  agu_idx_rdy
  );

  modport slave (
    input  agu_idx_vld,
    input  agu_idx_offset,
    input  agu_idx_vmask,
    input  agu_idx_last,
    output agu_idx_rdy
  );
endinterface

// File: rtl/xpu_vpu_pc_tn_vlsu_index_icq_rd.sv
// VLSU ICQ read side: scans entries from a wrapping pointer into a one-deep AGU
// output register. Optional masked-element skip: XPU_VPU_PC_TN_ICQ_MASK_SKIP_EN.
module xpu_vpu_pc_tn_vlsu_index_icq_rd #(
  parameter int ENTRY_NUM = 8,
  parameter int IDX_WIDTH = 64,
  parameter int ELEM_W    = 8
) (
  input  logic                              vv_icq_rd_clk,
  input  logic                              cpurst_b,
  input  logic                              giu_xx_async_flush,
  input  logic                              vv_icq_rd_start,
  input  logic [ELEM_W-1:0]                 vv_icq_rd_elem_num,
  input  logic [ENTRY_NUM-1:0]              vv_icq_entry_vld_v,
  input  logic [ENTRY_NUM-1:0]              vv_icq_entry_vmask_v,
  input  logic [ENTRY_NUM*IDX_WIDTH-1:0]    vv_icq_idx_offset_flat,
  output logic [ENTRY_NUM-1:0]              vv_icq_entry_rls_vld_v,
  xpu_vpu_pc_tn_vlsu_index_icq_rd_if.master agu,
  output logic                              vv_icq_rd_busy,
  output logic                              vv_icq_rd_done
);
  localparam int PTR_W = $clog2(ENTRY_NUM);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [ELEM_W-1:0]    issued_cnt_q;
  logic [ELEM_W-1:0]    elem_num_q;
  logic                 done_q;

  logic                 vld_p1;
  logic [IDX_WIDTH-1:0] offset_p1;
  logic                 vmask_p1;
  logic                 last_p1;

  logic [IDX_WIDTH-1:0] ent_offset [ENTRY_NUM];
  logic                 cur_vld, cur_vmask, accept, out_free;
  logic                 take, load, take_last, drain_done, start_ok;

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_unpack
    assign ent_offset[i] = vv_icq_idx_offset_flat[i*IDX_WIDTH +: IDX_WIDTH];
  end

  always_comb begin
    cur_vld    = vv_icq_entry_vld_v[rd_ptr_q];
    cur_vmask  = vv_icq_entry_vmask_v[rd_ptr_q];
    accept     = vld_p1 & agu.agu_idx_rdy;
    out_free   = ~vld_p1 | accept;
`ifdef XPU_VPU_PC_TN_ICQ_MASK_SKIP_EN
    // A masked element is retired without occupying the output register.
    take       = (state_q == RUN) & cur_vld & (out_free | ~cur_vmask) & ~giu_xx_async_flush;
    load       = take & cur_vmask;
`else
    take       = (state_q == RUN) & cur_vld & out_free & ~giu_xx_async_flush;
    load       = take;
`endif
    take_last  = take & ((issued_cnt_q + ELEM_W'(1)) == elem_num_q);
    drain_done = (state_q == DRAIN) & out_free;
    start_ok   = (state_q == IDLE) & vv_icq_rd_start & ~giu_xx_async_flush;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (vv_icq_rd_start)
                 state_d = (vv_icq_rd_elem_num == '0) ? DRAIN : RUN;
      RUN:     if (take_last)  state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (giu_xx_async_flush) state_d = IDLE;
  end

  always_ff @(posedge vv_icq_rd_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      issued_cnt_q <= '0;
      elem_num_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= drain_done & ~giu_xx_async_flush;
      if (giu_xx_async_flush) begin
        rd_ptr_q     <= '0;
        issued_cnt_q <= '0;
      end else if (start_ok) begin
        issued_cnt_q <= '0;
        elem_num_q   <= vv_icq_rd_elem_num;
      end else if (take) begin
        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
        issued_cnt_q <= issued_cnt_q + ELEM_W'(1);
      end
    end
  end

  // Stage p1: AGU output register
  always_ff @(posedge vv_icq_rd_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_p1    <= 1'b0;
      offset_p1 <= '0;
      vmask_p1  <= 1'b0;
      last_p1   <= 1'b0;
    end else if (giu_xx_async_flush) begin
      vld_p1    <= 1'b0;
    end else if (load) begin
      vld_p1    <= 1'b1;
      offset_p1 <= ent_offset[rd_ptr_q];
      vmask_p1  <= cur_vmask;
      last_p1   <= take_last;
    end else if (accept) begin
      vld_p1    <= 1'b0;
    end
  end

  assign vv_icq_entry_rls_vld_v = take ? (ENTRY_NUM'(1) << rd_ptr_q) : '0;
  assign agu.agu_idx_vld        = vld_p1;
  assign agu.agu_idx_offset     = offset_p1;
  assign agu.agu_idx_vmask      = vmask_p1;
  assign agu.agu_idx_last       = last_p1;
  assign vv_icq_rd_busy         = (state_q != IDLE);
  assign vv_icq_rd_done         = done_q & ~giu_xx_async_flush;

endmodule

// File: doc/xpu_vpu_pc_tn_vlsu_index_icq_rd.md
# xpu_vpu_pc_tn_vlsu_index_icq_rd

Read side of the VLSU index-offset queue (ICQ) for indexed vector loads/stores. It scans ICQ entries in order from a wrapping read pointer and moves each valid entry's index offset and vmask into a one-deep output register toward the address generator (AGU). It pulses the per-entry release strobe that frees the entry, and counts elements per instruction to signal completion. It sits between the ICQ entry array and the VLSU AGU.

## Interface
Parameters:
- ENTRY_NUM, 8, number of ICQ entries; power of two, ≥2
- IDX_WIDTH, 64, index offset width (equals `XPU_VPU_PC_TN_IDX_WIDTH`)
- ELEM_W, 8, element-count width

Ports:
- vv_icq_rd_clk  in  1  clock
- cpurst_b  in  1  reset; one clock; reset is asynchronous and active-low
- giu_xx_async_flush  in  1  flush; abort all activity
- vv_icq_rd_start  in  1  start pulse for one instruction; honoured only in IDLE
- vv_icq_rd_elem_num  in  ELEM_W  element count; sampled with start
- vv_icq_entry_vld_v  in  ENTRY_NUM  per-entry valid
- vv_icq_entry_vmask_v  in  ENTRY_NUM  per-entry vmask
- vv_icq_idx_offset_flat  in  ENTRY_NUM*IDX_WIDTH  entry i at bits [i*IDX_WIDTH +: IDX_WIDTH]
- vv_icq_entry_rls_vld_v  out  ENTRY_NUM  one-hot-or-zero release strobe, combinational
- agu_idx_vld  out  1  output register valid
- agu_idx_rdy  in  1  AGU accept
- agu_idx_offset  out  IDX_WIDTH  index offset
- agu_idx_vmask  out  1  element mask
- agu_idx_last  out  1  final element of the instruction
- vv_icq_rd_busy  out  1  state != IDLE
- vv_icq_rd_done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start with elem_num≠0.
  - IDLE→DRAIN on start with elem_num=0.
  - RUN→DRAIN in the cycle the elem_num-th element is taken.
  - DRAIN→IDLE when the output register is empty. rd_done pulses in the cycle after that condition holds in DRAIN.
- Take condition: state=RUN, entry_vld_v[rd_ptr]=1, and the output register is empty or agu_idx_vld&agu_idx_rdy is true in the same cycle.
- On take:
  - rls_vld_v[rd_ptr]=1 that cycle.
  - The output register loads offset and vmask.
  - agu_idx_last is set if issued_cnt+1 == elem_num.
  - rd_ptr is incremented modulo ENTRY_NUM, wrapping from ENTRY_NUM-1 to 0.
  - issued_cnt is incremented.
- If the output is accepted with no take, agu_idx_vld clears.
- Output register contents hold stable while agu_idx_vld=1 and agu_idx_rdy=0.
- Flush: asynchronous abort of pending work, applied in the flush cycle.
  - The next state is IDLE.
  - agu_idx_vld→0, rd_ptr→0, issued_cnt→0.
  - No rls strobe and no done pulse in the flush cycle.
  - Flush has priority over start and take.
- Start while busy is ignored.
- rd_ptr persists across instructions and is reset only by reset or flush.

## Timing
- Reset values:
  - state=IDLE, rd_ptr=0, issued_cnt=0.
  - agu_idx_vld=0, agu_idx_offset=0, agu_idx_vmask=0, agu_idx_last=0.
  - busy=0, done=0, rls_vld_v=0.
- Start at cycle 0 → busy=1 at cycle 1. The first take can occur at cycle 1, and agu_idx_vld is high at cycle 2.
- Entry-to-AGU latency is one cycle. The released entry's vld falls the cycle after rls.
- Throughput is 1 element/cycle with agu_idx_rdy held high and entries valid.
- elem_num=0: start at cycle 0 → done pulse at cycle 2; busy is high at cycle 1 only.
- The last element is accepted at cycle N → done at N+1 and busy=0 at N+1.

## Configuration
- XPU_VPU_PC_TN_ICQ_MASK_SKIP_EN defined:
  - An entry taken with vmask=0 is released and counted but not loaded into the output register.
  - It does not require output-register space.
  - At most one entry is released per cycle.
  - If the final element is masked, DRAIN waits only for the output register to empty.
- XPU_VPU_PC_TN_ICQ_MASK_SKIP_EN undefined: masked entries are presented to the AGU with agu_idx_vmask=0, like any other element.

## Test plan
- Reset then idle: all outputs hold reset values for 10 cycles.
- elem_num=3, all 8 entries valid, offsets 0x10/0x20/0x30, rdy=1 → rls at entries 0,1,2 in consecutive cycles; AGU sees 0x10,0x20,0x30 with last on 0x30; done one cycle after the last accept; rd_ptr=3.
- Backpressure: rdy=0 for 4 cycles with vld=1 → offset is stable and exactly one entry is released; after rdy=1 the stream resumes with no loss or duplication.
- Wrap: rd_ptr=6, elem_num=4 → entries 6,7,0,1 are released in order.
- Flush in RUN with agu_idx_vld=1 → next cycle vld=0, busy=0, rd_ptr=0, no done pulse; a following start with elem_num=1 completes normally.
- With XPU_VPU_PC_TN_ICQ_MASK_SKIP_EN: vmask 1,0,1 → AGU sees 2 elements, entries 0–2 are all released, and done fires.
